passcode_entry: RTL and testbench

Keypad front-end that sits directly upstream of `safe_vault`. It collects hex key presses into the 16-bit `passcode` bus and asserts `Enter_PSW` so the vault compares a stable, fully assembled code. Short entries, timeouts and vault lockout are handled here, so `safe_vault` only ever sees complete codes.

---
 rtl/passcode_entry.sv | 175 +++++++++++++++++
 tb/tb_passcode_entry.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/passcode_entry.sv
// rtl/passcode_entry.sv - hex keypad front-end that assembles and submits passcodes to safe_vault
module passcode_entry #(
    parameter int NUM_DIGITS   = 4,
    parameter int DIGIT_W      = 4,
    parameter int HOLD_CYCLES  = 8,
    parameter int IDLE_TIMEOUT = 1000
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              key_valid,
    input  logic [DIGIT_W-1:0]                key_code,
    input  logic                              key_enter,
    input  logic                              key_clear,
    input  logic                              lockout,
    output logic [NUM_DIGITS*DIGIT_W-1:0]     passcode,
    output logic                              Enter_PSW,
    output logic [$clog2(NUM_DIGITS+1)-1:0]   digit_cnt,
    output logic                              entry_err
);

    localparam int W  = NUM_DIGITS * DIGIT_W;
    localparam int CW = $clog2(NUM_DIGITS + 1);
    localparam int HW = $clog2(HOLD_CYCLES + 1);
    localparam int TW = $clog2(IDLE_TIMEOUT + 1);

    localparam logic [CW-1:0] FULL_CNT  = CW'(NUM_DIGITS);
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);
    localparam logic [TW-1:0] TO_LAST   = TW'(IDLE_TIMEOUT - 1);
    localparam logic [TW-1:0] TO_MAX    = TW'(IDLE_TIMEOUT);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        COLLECT = 3'd1,
        FULL    = 3'd2,
        SUBMIT  = 3'd3,
        LOCKED  = 3'd4
    } state_t;

    state_t        state;
    logic [HW-1:0] hold_cnt;
    logic [TW-1:0] idle_cnt;

    logic key_valid_q;
    logic key_enter_q;
    logic key_clear_q;

    logic dig_ev;
    logic ent_ev;
    logic clr_ev;

    // A held key produces a single event on its rising level
    assign dig_ev = key_valid & ~key_valid_q;
    assign ent_ev = key_enter & ~key_enter_q;
    assign clr_ev = key_clear & ~key_clear_q;

    // Key history keeps tracking in every state so a key held through lockout yields no event later
    always_ff @(posedge clk) begin
        if (reset) begin
            key_valid_q <= 1'b0;
            key_enter_q <= 1'b0;
            key_clear_q <= 1'b0;
        end else begin
            key_valid_q <= key_valid;
            key_enter_q <= key_enter;
            key_clear_q <= key_clear;
        end
    end

    // Entry FSM: lockout level beats clear, clear beats enter, enter beats digit
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            passcode  <= '0;
            digit_cnt <= '0;
            Enter_PSW <= 1'b0;
            entry_err <= 1'b0;
            hold_cnt  <= '0;
            idle_cnt  <= '0;
        end else begin
            entry_err <= 1'b0;
            if (lockout) begin
                state     <= LOCKED;
                passcode  <= '0;
                digit_cnt <= '0;
                Enter_PSW <= 1'b0;
                hold_cnt  <= '0;
                idle_cnt  <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        if (clr_ev) begin
                            state <= IDLE;
                        end else if (ent_ev) begin
                            entry_err <= 1'b1;
                        end else if (dig_ev) begin
                            passcode  <= W'(key_code);
                            digit_cnt <= CW'(1);
                            idle_cnt  <= '0;
                            state     <= (NUM_DIGITS == 1) ? FULL : COLLECT;
                        end
                    end
                    COLLECT: begin
                        if (clr_ev) begin
                            passcode  <= '0;
                            digit_cnt <= '0;
                            idle_cnt  <= '0;
                            state     <= IDLE;
                        end else if (ent_ev) begin
                            entry_err <= 1'b1;
                            passcode  <= '0;
                            digit_cnt <= '0;
                            idle_cnt  <= '0;
                            state     <= IDLE;
                        end else if (dig_ev) begin
                            passcode  <= (passcode << DIGIT_W) | W'(key_code);
                            digit_cnt <= digit_cnt + CW'(1);
                            idle_cnt  <= '0;
                            if (digit_cnt + CW'(1) == FULL_CNT) begin
                                state <= FULL;
                            end
                        end else if (idle_cnt == TO_LAST) begin
                            passcode  <= '0;
                            digit_cnt <= '0;
                            idle_cnt  <= '0;
                            state     <= IDLE;
                        end else if (idle_cnt != TO_MAX) begin
                            idle_cnt <= idle_cnt + TW'(1);
                        end
                    end
                    FULL: begin
                        if (clr_ev) begin
                            passcode  <= '0;
                            digit_cnt <= '0;
                            idle_cnt  <= '0;
                            state     <= IDLE;
                        end else if (ent_ev) begin
                            Enter_PSW <= 1'b1;
                            hold_cnt  <= '0;
                            idle_cnt  <= '0;
                            state     <= SUBMIT;
                        end else if (dig_ev) begin
                            entry_err <= 1'b1;
                            idle_cnt  <= '0;
                        end else if (idle_cnt == TO_LAST) begin
                            passcode  <= '0;
                            digit_cnt <= '0;
                            idle_cnt  <= '0;
                            state     <= IDLE;
                        end else if (idle_cnt != TO_MAX) begin
                            idle_cnt <= idle_cnt + TW'(1);
                        end
                    end
                    SUBMIT: begin
                        if (hold_cnt == HOLD_LAST) begin
                            Enter_PSW <= 1'b0;
                            passcode  <= '0;
                            digit_cnt <= '0;
                            hold_cnt  <= '0;
                            state     <= IDLE;
                        end else begin
                            hold_cnt <= hold_cnt + HW'(1);
                        end
                    end
                    LOCKED: begin
                        state <= IDLE;
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_passcode_entry.sv
// tb/tb_passcode_entry.sv - directed-vector bench for passcode_entry
module tb_passcode_entry;

    logic        clk;
    logic        reset;
    logic        key_valid;
    logic [3:0]  key_code;
    logic        key_enter;
    logic        key_clear;
    logic        lockout;
    logic [15:0] passcode;
    logic        Enter_PSW;
    logic [2:0]  digit_cnt;
    logic        entry_err;

    int n_vec;
    int n_err;

    passcode_entry #(
        .NUM_DIGITS  (4),
        .DIGIT_W     (4),
        .HOLD_CYCLES (8),
        .IDLE_TIMEOUT(1000)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .key_valid(key_valid),
        .key_code (key_code),
        .key_enter(key_enter),
        .key_clear(key_clear),
        .lockout  (lockout),
        .passcode (passcode),
        .Enter_PSW(Enter_PSW),
        .digit_cnt(digit_cnt),
        .entry_err(entry_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic press(input logic [3:0] d);
        key_valid = 1'b1;
        key_code  = d;
        step();
        key_valid = 1'b0;
        step();
    endtask

    task automatic press_clear();
        key_clear = 1'b1;
        step();
        key_clear = 1'b0;
        step();
    endtask

    task automatic enter_code(input logic [3:0] a, input logic [3:0] b,
                              input logic [3:0] c, input logic [3:0] d);
        press(a);
        press(b);
        press(c);
        press(d);
    endtask

    initial begin
        n_vec     = 0;
        n_err     = 0;
        reset     = 1'b1;
        key_valid = 1'b0;
        key_code  = 4'h0;
        key_enter = 1'b0;
        key_clear = 1'b0;
        lockout   = 1'b0;
        step();
        step();
        check_eq("rst_passcode", passcode, 16'h0);
        check_eq("rst_enter", Enter_PSW, 1'b0);
        check_eq("rst_cnt", digit_cnt, 3'd0);
        check_eq("rst_err", entry_err, 1'b0);
        reset = 1'b0;
        step();

        // Full code and submit
        press(4'hE);
        check_eq("first_digit", passcode, 16'h000E);
        check_eq("first_cnt", digit_cnt, 3'd1);
        press(4'h4);
        press(4'h6);
        press(4'h9);
        check_eq("full_passcode", passcode, 16'hE469);
        check_eq("full_cnt", digit_cnt, 3'd4);
        key_enter = 1'b1;
        step();
        key_enter = 1'b0;
        check_eq("sub_enter0", Enter_PSW, 1'b1);
        check_eq("sub_code0", passcode, 16'hE469);
        for (int i = 1; i < 8; i++) begin
            step();
            check_eq("sub_enter_hold", Enter_PSW, 1'b1);
            check_eq("sub_code_hold", passcode, 16'hE469);
        end
        step();
        check_eq("sub_enter_end", Enter_PSW, 1'b0);
        check_eq("sub_code_end", passcode, 16'h0);
        check_eq("sub_cnt_end", digit_cnt, 3'd0);

        // Short entry rejected
        press(4'hE);
        press(4'h4);
        key_enter = 1'b1;
        step();
        key_enter = 1'b0;
        check_eq("short_err", entry_err, 1'b1);
        check_eq("short_enter", Enter_PSW, 1'b0);
        check_eq("short_code", passcode, 16'h0);
        check_eq("short_cnt", digit_cnt, 3'd0);
        step();
        check_eq("short_err_drop", entry_err, 1'b0);
        enter_code(4'hD, 4'h4, 4'h6, 4'h9);
        key_enter = 1'b1;
        step();
        key_enter = 1'b0;
        check_eq("d469_enter", Enter_PSW, 1'b1);
        check_eq("d469_code", passcode, 16'hD469);
        repeat (8) step();
        check_eq("d469_done", Enter_PSW, 1'b0);

        // Fifth digit rejected, then clear beats enter
        enter_code(4'hE, 4'h4, 4'h6, 4'h9);
        key_valid = 1'b1;
        key_code  = 4'h7;
        step();
        key_valid = 1'b0;
        check_eq("fifth_err", entry_err, 1'b1);
        check_eq("fifth_code", passcode, 16'hE469);
        check_eq("fifth_cnt", digit_cnt, 3'd4);
        step();
        key_clear = 1'b1;
        key_enter = 1'b1;
        step();
        key_clear = 1'b0;
        key_enter = 1'b0;
        check_eq("clr_code", passcode, 16'h0);
        check_eq("clr_cnt", digit_cnt, 3'd0);
        check_eq("clr_enter", Enter_PSW, 1'b0);
        check_eq("clr_err", entry_err, 1'b0);
        step();
        check_eq("clr_enter_after", Enter_PSW, 1'b0);

        // Timeout boundary: last key at edge k, discard at edge k+1000
        press(4'hE);
        press(4'h4);
        repeat (998) step();
        check_eq("to_999_code", passcode, 16'h00E4);
        check_eq("to_999_cnt", digit_cnt, 3'd2);
        step();
        check_eq("to_1000_code", passcode, 16'h0);
        check_eq("to_1000_cnt", digit_cnt, 3'd0);
        check_eq("to_1000_err", entry_err, 1'b0);

        // Key at cycle 999 keeps the entry alive
        press(4'hE);
        repeat (997) step();
        key_valid = 1'b1;
        key_code  = 4'h4;
        step();
        key_valid = 1'b0;
        check_eq("late_key_code", passcode, 16'h00E4);
        check_eq("late_key_cnt", digit_cnt, 3'd2);
        step();
        press(4'h6);
        press(4'h9);
        check_eq("late_full", passcode, 16'hE469);
        press_clear();
        check_eq("late_clear", digit_cnt, 3'd0);

        // Lockout aborts submit, held key ignored on release
        enter_code(4'hE, 4'h4, 4'h6, 4'h9);
        key_enter = 1'b1;
        step();
        key_enter = 1'b0;
        step();
        step();
        check_eq("lk_pre_enter", Enter_PSW, 1'b1);
        lockout   = 1'b1;
        key_valid = 1'b1;
        key_code  = 4'h5;
        step();
        check_eq("lk_enter", Enter_PSW, 1'b0);
        check_eq("lk_code", passcode, 16'h0);
        check_eq("lk_cnt", digit_cnt, 3'd0);
        step();
        check_eq("lk_hold_cnt", digit_cnt, 3'd0);
        lockout = 1'b0;
        step();
        step();
        check_eq("lk_rel_cnt", digit_cnt, 3'd0);
        check_eq("lk_rel_code", passcode, 16'h0);
        key_valid = 1'b0;
        step();
        press(4'hA);
        check_eq("lk_recover_code", passcode, 16'h000A);
        check_eq("lk_recover_cnt", digit_cnt, 3'd1);
        press_clear();

        // Reset mid-collect
        press(4'hE);
        press(4'h4);
        reset = 1'b1;
        step();
        check_eq("rc_code", passcode, 16'h0);
        check_eq("rc_cnt", digit_cnt, 3'd0);
        reset = 1'b0;
        step();

        // Reset mid-submit
        enter_code(4'h1, 4'h2, 4'h3, 4'h4);
        key_enter = 1'b1;
        step();
        key_enter = 1'b0;
        step();
        check_eq("rs_pre_enter", Enter_PSW, 1'b1);
        reset = 1'b1;
        step();
        check_eq("rs_enter", Enter_PSW, 1'b0);
        check_eq("rs_code", passcode, 16'h0);
        check_eq("rs_cnt", digit_cnt, 3'd0);
        check_eq("rs_err", entry_err, 1'b0);
        reset = 1'b0;
        step();
        step();
        check_eq("rs_stay_low", Enter_PSW, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
